// File: rtl/edgeconv_sched_if.sv
// Signal bundle between the two pixel requesters, the shared edgeconv core and the
// result consumer. The scheduler takes the slave view; the surrounding logic takes master.
interface edgeconv_sched_if;
  logic       req0_valid;
  logic [7:0] req0_pixel;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_pixel;
  logic       req1_ready;
  logic       core_valid_in;
  logic [7:0] core_pixel_in;
  logic       core_valid_out;
  logic [3:0] core_digit_out;
  logic       res_valid;
  logic       res_src;
  logic [3:0] res_digit;
  logic       res_timeout;
  logic       busy;

  modport slave (
    input  req0_valid, req0_pixel, req1_valid, req1_pixel, core_valid_out, core_digit_out,
    output req0_ready, req1_ready, core_valid_in, core_pixel_in,
    output res_valid, res_src, res_digit, res_timeout, busy
  );

  modport master (
    output req0_valid, req0_pixel, req1_valid, req1_pixel, core_valid_out, core_digit_out,
    input  req0_ready, req1_ready, core_valid_in, core_pixel_in,
    input  res_valid, res_src, res_digit, res_timeout, busy
  );
endinterface

// File: rtl/edgeconv_sched.sv
// Frame-level round-robin scheduler sharing one edgeconv core between two pixel requesters;
// forwards a granted frame, then waits (with timeout) for the digit and returns it tagged.
module edgeconv_sched #(
  parameter int unsigned FRAME_PIXELS = 784,
  parameter int unsigned TIMEOUT      = 4096
) (
  input logic             clk,
  input logic             rst,
  edgeconv_sched_if.slave bus
);

  localparam int unsigned CntW = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam int unsigned TmrW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] LastPix  = CntW'(FRAME_PIXELS - 1);
  localparam logic [TmrW-1:0] LastTick = TmrW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StStream, StWait, StResult} state_e;

  state_e          state_q, state_d;
  logic            grant_q, grant_d;
  logic            last_grant_q, last_grant_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [TmrW-1:0] tmr_q, tmr_d;
  logic [3:0]      digit_q, digit_d;
  logic            timeout_q, timeout_d;
  logic            fwd_valid_q, fwd_valid_d;
  logic [7:0]      fwd_pixel_q, fwd_pixel_d;

  logic            sel_valid;
  logic [7:0]      sel_pixel;
  logic            hs;

  assign sel_valid = grant_q ? bus.req1_valid : bus.req0_valid;
  assign sel_pixel = grant_q ? bus.req1_pixel : bus.req0_pixel;
  assign hs        = (state_q == StStream) && sel_valid;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    tmr_d        = tmr_q;
    digit_d      = digit_q;
    timeout_d    = timeout_q;
    fwd_valid_d  = hs;
    fwd_pixel_d  = hs ? sel_pixel : fwd_pixel_q;

    case (state_q)
      StIdle: begin
        if (bus.req0_valid || bus.req1_valid) begin
          // On a tie the requester not served last wins.
          grant_d      = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
          last_grant_d = grant_d;
          cnt_d        = '0;
          state_d      = StStream;
        end
      end
      StStream: begin
        if (hs) begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == LastPix) begin
            tmr_d   = '0;
            state_d = StWait;
          end
        end
      end
      StWait: begin
        tmr_d = tmr_q + TmrW'(1);
        // A core result arriving on the expiry cycle takes priority over the timeout.
        if (bus.core_valid_out) begin
          digit_d   = bus.core_digit_out;
          timeout_d = 1'b0;
          state_d   = StResult;
        end else if (tmr_q == LastTick) begin
          digit_d   = 4'hF;
          timeout_d = 1'b1;
          state_d   = StResult;
        end
      end
      StResult: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      tmr_q        <= '0;
      digit_q      <= 4'h0;
      timeout_q    <= 1'b0;
      fwd_valid_q  <= 1'b0;
      fwd_pixel_q  <= 8'h00;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      tmr_q        <= tmr_d;
      digit_q      <= digit_d;
      timeout_q    <= timeout_d;
      fwd_valid_q  <= fwd_valid_d;
      fwd_pixel_q  <= fwd_pixel_d;
    end
  end

  assign bus.req0_ready    = (state_q == StStream) && !grant_q;
  assign bus.req1_ready    = (state_q == StStream) && grant_q;
  assign bus.core_valid_in = fwd_valid_q;
  assign bus.core_pixel_in = fwd_pixel_q;
  assign bus.res_valid     = (state_q == StResult);
  assign bus.res_src       = grant_q;
  assign bus.res_digit     = digit_q;
  assign bus.res_timeout   = timeout_q;
  assign bus.busy          = (state_q != StIdle);

endmodule

// File: doc/edgeconv_sched.md
# edgeconv_sched

Frame-level scheduler that shares one `edgeconv` classification core between two pixel-stream requesters. It grants the core to one requester for a whole frame with round-robin arbitration, then forwards that frame's pixels to the core. It waits for the core's digit result, with a timeout guard, and returns the result tagged with the source. It sits between the two sensor/host streams and the core inside the top level.

## Interface
- `FRAME_PIXELS`, 784: pixels per frame. Must be ≥ 2.
- `TIMEOUT`, 4096: maximum cycles spent in WAIT before the result is forced.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset. The top level drives the core's `rst_n` from `~rst`.
- `req0_valid`, `req1_valid`  in  1  requester has a pixel available.
- `req0_pixel`, `req1_pixel`  in  8  pixel data.
- `req0_ready`, `req1_ready`  out  1  pixel accepted when valid & ready.
- `core_valid_in`  out  1  pixel strobe to the core.
- `core_pixel_in`  out  8  pixel to the core.
- `core_valid_out`  in  1  core result strobe.
- `core_digit_out`  in  4  core result digit.
- `res_valid`  out  1  one-cycle result pulse.
- `res_src`  out  1  requester index the result belongs to.
- `res_digit`  out  4  classified digit; 4'hF on timeout.
- `res_timeout`  out  1  result was forced by timeout.
- `busy`  out  1  state ≠ IDLE.

## Operation
- State machine states: IDLE, STREAM, WAIT, RESULT.
- **IDLE**
  - If exactly one `reqN_valid` is high, grant N.
  - If both are high, grant the requester not granted last. `last_grant` resets to 1, so req0 wins the first tie.
  - On a grant: update `last_grant`, clear the pixel counter, go to STREAM.
- **STREAM**
  - `reqN_ready = (state==STREAM) && (grant==N)`. This is combinational from registered state; the ungranted ready is always 0.
  - Each handshake registers `core_valid_in <= 1` and `core_pixel_in <= pixel`; otherwise `core_valid_in <= 0`.
  - `core_pixel_in` holds its last value when idle.
  - The pixel counter (width clog2(FRAME_PIXELS)) increments per handshake.
  - On the handshake with counter == FRAME_PIXELS-1, go to WAIT and clear the timer.
  - Gaps where valid is low are allowed; the counter holds during them.
- **WAIT**
  - The timer increments each cycle.
  - If `core_valid_out` is high: latch `core_digit_out`, set timeout = 0, go to RESULT.
  - Else if timer == TIMEOUT-1: set digit = 4'hF, timeout = 1, go to RESULT.
  - If `core_valid_out` and timer expiry coincide, the core result wins.
- **RESULT**: `res_valid = 1` for exactly one cycle, with `res_src = grant` and the latched digit/timeout; then go to IDLE.
- `core_valid_out` is sampled only in WAIT. It is ignored in IDLE, STREAM and RESULT.
- Results carry no backpressure. The consumer must accept the pulse.
- `busy` reflects the registered state.

## Timing
- **Reset values:**
  - state = IDLE; `last_grant` = 1.
  - `req*_ready` = 0, `core_valid_in` = 0, `core_pixel_in` = 0.
  - `res_valid` = 0, `res_src` = 0, `res_digit` = 0, `res_timeout` = 0, `busy` = 0.
- **Grant:** `reqN_valid` seen in IDLE at cycle t → STREAM and `reqN_ready` = 1 at t+1. The first pixel is accepted no earlier than t+1.
- **Forwarding latency:** a pixel accepted at cycle k appears on `core_pixel_in` with `core_valid_in` at k+1. The last pixel's strobe occurs in the first WAIT cycle.
- **Result latency:** `core_valid_out` at cycle w (in WAIT) → `res_valid` at w+1 → IDLE at w+2. The next grant's ready is asserted at w+3 at the earliest.
- **Timeout:** entering WAIT at cycle s with no core result → `res_valid` with `res_timeout` at s+TIMEOUT.
- **Throughput:** at most one frame in flight. The minimum frame period is FRAME_PIXELS + core latency + 3 cycles.
- **Reset mid-operation:** immediate return to reset values. The partial frame is discarded and no result is emitted. The requester must restart the frame from pixel 0.
- A requester dropping valid in IDLE before being granted is not an error; no grant occurs.

## Test plan
- **Single frame, req0:** 784 back-to-back pixels; core returns digit 7 after 20 cycles → one `res_valid` with `res_src` = 0, `res_digit` = 7, `res_timeout` = 0. Exactly 784 `core_valid_in` pulses, each one cycle after its handshake, with data intact.
- **Contention:** both valid continuously for 4 frames → grants alternate 0,1,0,1 (req0 first). `req1_ready` stays 0 while req0 streams.
- **Gapped stream:** req1 toggles valid every other cycle → counter and forwarding are correct. The frame ends after exactly 784 handshakes; `core_valid_in` count is 784.
- **Timeout:** core never asserts `core_valid_out`, TIMEOUT = 16 → `res_valid` exactly 16 cycles after WAIT entry, with `res_digit` = 4'hF and `res_timeout` = 1.
- **Spurious and coincident results:**
  - `core_valid_out` pulsed during STREAM → no `res_valid`.
  - `core_valid_out` (digit 3) coincident with timer expiry → `res_digit` = 3, `res_timeout` = 0.
- **Reset mid-frame:** assert `rst` after 300 pixels → all outputs at reset values asynchronously. After release, a fresh 784-pixel frame from req0 completes normally; req0 wins the first tie again.
